// File: rtl/hid_pkg.sv
// rtl/hid_pkg.sv - shared constants for the HID serial receiver
package hid_pkg;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int BLANK_CYCLES   = 3;
endpackage

// File: rtl/hid_rx_fifo.sv
// rtl/hid_rx_fifo.sv - show-ahead frame FIFO with wrap-bit pointers
module hid_rx_fifo import hid_pkg::*; #(
    parameter int WIDTH = DEF_FRAME_BITS,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/hid_serial_rx.sv
// rtl/hid_serial_rx.sv - three-wire HID link receiver with frame FIFO and sticky flags
module hid_serial_rx import hid_pkg::*; #(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  hid_clk,
    input  logic                  hid_dat,
    input  logic                  hid_str,
    output logic [FRAME_BITS-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [LW-1:0]         fifo_level,
    output logic                  err_flag,
    output logic                  ovf_flag,
    input  logic                  clr_flags
);
    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(FRAME_BITS + 1);

    // Sync chain bit order: {str, dat, clk}.
    logic [2:0]            s1;
    logic [2:0]            s2;
    logic [2:0]            s3;
    logic [1:0]            blank;
    logic [FRAME_BITS-1:0] shift;
    logic [FRAME_BITS:0]   shift_ext;
    logic [CW-1:0]         bit_cnt;
    logic                  clk_rise;
    logic                  str_rise;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  set_err;
    logic                  set_ovf;

    assign clk_rise  = s2[0] & ~s3[0] & (blank == 2'd0);
    assign str_rise  = s2[2] & ~s3[2] & (blank == 2'd0);
    assign shift_ext = {shift, s2[1]};
    assign push      = str_rise & (bit_cnt == CNT_FRAME);
    assign set_err   = str_rise & (bit_cnt != '0) & (bit_cnt != CNT_FRAME);
    assign pop       = rd_valid & rd_ready;
    assign set_ovf   = push & full & ~pop;
    assign rd_valid  = ~empty;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            blank    <= 2'(BLANK_CYCLES);
            shift    <= '0;
            bit_cnt  <= '0;
            err_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            s1 <= {hid_str, hid_dat, hid_clk};
            s2 <= s1;
            s3 <= s2;
            if (blank != 2'd0) begin
                blank <= blank - 2'd1;
            end
            // The strobe takes priority; a coincident clock edge is dropped.
            if (str_rise) begin
                bit_cnt <= '0;
            end else if (clk_rise) begin
                shift <= shift_ext[FRAME_BITS-1:0];
                if (bit_cnt != CNT_MAX) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            err_flag <= (err_flag & ~clr_flags) | set_err;
            ovf_flag <= (ovf_flag & ~clr_flags) | set_ovf;
        end
    end

    hid_rx_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (push),
        .push_data (shift),
        .pop       (pop),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .level     (fifo_level)
    );
endmodule

// File: tb/tb_hid_serial_rx.sv
// tb/tb_hid_serial_rx.sv - directed self-checking bench for hid_serial_rx
module tb_hid_serial_rx;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        hid_clk = 1'b0;
    logic        hid_dat = 1'b0;
    logic        hid_str = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [3:0]  fifo_level;
    logic        err_flag;
    logic        ovf_flag;
    logic        clr_flags = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    hid_serial_rx #(.FRAME_BITS(16), .FIFO_DEPTH(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .hid_clk    (hid_clk),
        .hid_dat    (hid_dat),
        .hid_str    (hid_str),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_level (fifo_level),
        .err_flag   (err_flag),
        .ovf_flag   (ovf_flag),
        .clr_flags  (clr_flags)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_bit(input logic b);
        hid_dat = b;
        idle(3);
        hid_clk = 1'b1;
        idle(3);
        hid_clk = 1'b0;
        idle(3);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pulse_str();
        hid_str = 1'b1;
        idle(3);
        hid_str = 1'b0;
        idle(3);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        idle(1);
        rd_ready = 1'b0;
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        idle(2);
        sys_rst = 1'b0;
        idle(4);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", rd_data); end
        n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_checks++; if ({err_flag, ovf_flag} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {err_flag, ovf_flag}); end
    endtask

    task automatic test_basic_frame();
        send_bits(32'hA55C, 16);
        hid_str = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: got %b want 0", rd_valid); end
        @(posedge sys_clk);
        #1;
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 16'hA55C) begin n_fail++; $display("FAIL basic_data: got %h want a55c", rd_data); end
        n_checks++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL basic_level: got %0d want 1", fifo_level); end
        n_checks++; if ({err_flag, ovf_flag} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b want 00", {err_flag, ovf_flag}); end
        @(negedge sys_clk);
        hid_str = 1'b0;
        idle(3);
        pop_one();
        n_checks++; if ({rd_valid, rd_data} !== 17'h0) begin n_fail++; $display("FAIL basic_pop: got %b/%h want 0/0000", rd_valid, rd_data); end
    endtask

    task automatic test_bad_count();
        send_bits(32'h1234, 15);
        pulse_str();
        n_checks++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL err15: got %b want 1", err_flag); end
        n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL err15_level: got %0d want 0", fifo_level); end
        clear_flags();
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", err_flag); end
        // 17 bits; clr_flags coincides with the strobe detection so the set wins.
        send_bits(32'h1ABCD, 17);
        hid_str = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        clr_flags = 1'b1;
        @(negedge sys_clk);
        clr_flags = 1'b0;
        n_checks++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL err17_set_vs_clr: got %b want 1", err_flag); end
        n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL err17_level: got %0d want 0", fifo_level); end
        hid_str = 1'b0;
        idle(3);
        clear_flags();
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL err17_clr: got %b want 0", err_flag); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 9; k++) begin
            send_bits(32'(k), 16);
            pulse_str();
        end
        n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
        n_checks++; if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf_flag); end
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_err: got %b want 0", err_flag); end
        for (int k = 1; k <= 8; k++) begin
            n_checks++; if (rd_data !== 16'(k)) begin n_fail++; $display("FAIL ovf_pop%0d: got %h want %h", k, rd_data, 16'(k)); end
            pop_one();
        end
        n_checks++; if ({rd_valid, fifo_level} !== 5'h0) begin n_fail++; $display("FAIL ovf_drained: got %b/%0d want 0/0", rd_valid, fifo_level); end
        n_checks++; if (ovf_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf_flag); end
        clear_flags();
        n_checks++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", ovf_flag); end
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 8; k++) begin
            send_bits(32'h10 + 32'(k), 16);
            pulse_str();
        end
        send_bits(32'h18, 16);
        hid_str = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rd_ready = 1'b1;
        @(negedge sys_clk);
        rd_ready = 1'b0;
        n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL fullpp_level: got %0d want 8", fifo_level); end
        n_checks++; if (ovf_flag !== 1'b0) begin n_fail++; $display("FAIL fullpp_ovf: got %b want 0", ovf_flag); end
        hid_str = 1'b0;
        idle(3);
        for (int k = 1; k <= 8; k++) begin
            n_checks++; if (rd_data !== 16'h10 + 16'(k)) begin n_fail++; $display("FAIL fullpp_pop%0d: got %h want %h", k, rd_data, 16'h10 + 16'(k)); end
            pop_one();
        end
    endtask

    task automatic test_coincident_and_reset();
        send_bits(32'hBEEF, 16);
        hid_dat = 1'b1;
        hid_clk = 1'b1;
        hid_str = 1'b1;
        idle(3);
        hid_clk = 1'b0;
        hid_str = 1'b0;
        idle(3);
        n_checks++; if (rd_data !== 16'hBEEF) begin n_fail++; $display("FAIL coinc_data: got %h want beef", rd_data); end
        n_checks++; if ({err_flag, fifo_level} !== 5'h01) begin n_fail++; $display("FAIL coinc_state: got %b/%0d want 0/1", err_flag, fifo_level); end
        send_bits(32'h5, 3);
        pulse_str();
        send_bits(32'hA5, 8);
        do_reset();
        n_checks++; if ({rd_valid, rd_data, fifo_level} !== 21'h0) begin n_fail++; $display("FAIL midrst_out: got %b/%h/%0d want 0/0000/0", rd_valid, rd_data, fifo_level); end
        n_checks++; if ({err_flag, ovf_flag} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags: got %b want 00", {err_flag, ovf_flag}); end
        send_bits(32'h1234, 16);
        pulse_str();
        n_checks++; if (rd_data !== 16'h1234) begin n_fail++; $display("FAIL midrst_next: got %h want 1234", rd_data); end
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", err_flag); end
        pop_one();
    endtask

    task automatic test_blanking();
        hid_clk = 1'b1;
        do_reset();
        hid_clk = 1'b0;
        idle(3);
        send_bits(32'h00FF, 16);
        pulse_str();
        n_checks++; if ({err_flag, rd_data} !== 17'h000FF) begin n_fail++; $display("FAIL blank_clk: got %b/%h want 0/00ff", err_flag, rd_data); end
        hid_clk = 1'b1;
        hid_str = 1'b1;
        do_reset();
        n_checks++; if ({err_flag, fifo_level} !== 5'h0) begin n_fail++; $display("FAIL blank_both: got %b/%0d want 0/0", err_flag, fifo_level); end
        hid_clk = 1'b0;
        hid_str = 1'b0;
        idle(3);
        send_bits(32'h0F0F, 16);
        pulse_str();
        n_checks++; if ({err_flag, rd_data} !== 17'h00F0F) begin n_fail++; $display("FAIL blank_after: got %b/%h want 0/0f0f", err_flag, rd_data); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_bad_count();
        test_overflow();
        test_full_push_pop();
        test_coincident_and_reset();
        test_blanking();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hid_serial_rx.md
# hid_serial_rx

Receiver for the three-wire HID link (hid_clk, hid_dat, hid_str, already de-inverted at top level). It synchronises the asynchronous link into sys_clk, shifts in fixed-length key/scan frames and queues complete frames in a small show-ahead FIFO. The CPU-side peripheral drains the FIFO through a valid/ready port. Framing errors and FIFO overflows are reported as sticky flags.

## Interface
- FRAME_BITS, 16: bits per frame, 1..32.
- FIFO_DEPTH, 8: frames held; power of two, ≥2.
- sys_clk  in  1  single clock for all logic.
- sys_rst  in  1  reset; synchronous, active-high.
- hid_clk  in  1  link bit clock, async, active-high; data sampled on its rising edge.
- hid_dat  in  1  link data, async, MSB first.
- hid_str  in  1  link frame strobe, async; rising edge ends a frame.
- rd_data  out  FRAME_BITS  head-of-FIFO frame; 0 when empty.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  pop when rd_valid & rd_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored, 0..FIFO_DEPTH.
- err_flag  out  1  sticky: a strobe arrived with bit count ≠ FRAME_BITS.
- ovf_flag  out  1  sticky: a good frame was dropped because the FIFO was full.
- clr_flags  in  1  single-cycle pulse clears err_flag and ovf_flag.

## Operation
- Each link input passes through 2 flip-flops (s1, s2), then 1 history flip-flop (s3). Rising edge = s2 & ~s3.
- Blanking: a 2-bit counter is loaded with 3 on reset. While it is nonzero, the sync chain tracks the pins and every edge is ignored.
- Clock edge (no strobe edge that cycle): shift = {shift[FRAME_BITS-2:0], s2_dat}. bit_cnt increments and saturates at FRAME_BITS+1.
- Strobe edge: bit_cnt is evaluated, then reset to 0. A hid_clk edge in the same cycle is discarded (strobe wins).
  - bit_cnt == 0: ignored silently.
  - bit_cnt == FRAME_BITS: push shift. If the FIFO is full and no pop happens this cycle, drop the frame and set ovf_flag.
  - Any other count: drop the frame and set err_flag.
- FIFO is show-ahead.
  - Push and pop in the same cycle: both happen and the level is unchanged. This includes the full case, where the push is accepted.
  - Pop when empty: ignored.
- A flag set event in the same cycle as clr_flags: the flag ends set.
- Reset mid-frame: partial frame discarded, FIFO emptied, flags cleared.
- Reset values: rd_data 0, rd_valid 0, fifo_level 0, err_flag 0, ovf_flag 0, shift 0, bit_cnt 0, sync chain 0, blank counter 3.

## Timing
- Pin-to-detect latency: 2 sys_clk edges.
- hid_str rising at pin to rd_valid high: after the 3rd sys_clk rising edge, provided the FIFO was empty.
- Link requirement: each hid_clk and hid_str high and low phase lasts ≥2 sys_clk periods. hid_dat is stable ≥2 sys_clk periods around each hid_clk rise. Faster links are unsupported; edges may be lost.
- Pop: rd_data/rd_valid update the cycle after the rd_valid & rd_ready edge.
- fifo_level, err_flag and ovf_flag are registered and update 1 cycle after the causing event.
- rd_data is a combinational read of mem[rd_ptr], gated to 0 when empty.

## Structure
- Package hid_pkg holds:
  - default FRAME_BITS and FIFO_DEPTH constants;
  - the blanking length constant (3).
- Sub-module hid_rx_fifo holds:
  - parameterised show-ahead FIFO: push, push_data, pop, rd_data, empty, full, level;
  - pointers one bit wider than the address.
- Top holds: sync chain, edge detect, shifter, bit counter, flags.

## Test plan
- Send 16 bits 0xA55C, then a strobe → rd_valid high 3 cycles after the strobe pin edge, rd_data=0xA55C, fifo_level=1, flags 0.
- Send 15 bits, then a strobe; separately send 17 bits, then a strobe → err_flag=1, fifo_level=0; clr_flags → err_flag=0.
- Send 9 frames 0x0001..0x0009 with rd_ready=0 → fifo_level=8, ovf_flag=1. Pops return 0x0001..0x0008 in order.
- FIFO full, rd_ready=1 held while the 9th frame's strobe is detected → push accepted, ovf_flag=0, level stays 8.
- hid_clk and hid_str rise together after 16 bits → the clk edge is discarded and the 16-bit frame is pushed. Assert sys_rst after 8 bits of the next frame → outputs 0. Then send a full frame 0x1234 → 0x1234 is received, err_flag=0.
- Hold hid_clk and hid_str high through reset release → no err_flag and no bit counted during blanking.
